sha256_block_loader: RTL and testbench
======================================

# sha256_block_loader

Upstream feeder for the simplified SHA-256 core. On `start` it reads `NUM_OF_WORDS` consecutive 32-bit message words from word-addressed memory at `message_addr`, assembles them into a 16-word block with unused slots zeroed, and presents the block on a valid/ready handshake. Its `block_data` vector connects directly to the core's 16-word `mem_read_data` input. Padding and length insertion belong to the core; this block only fetches and zero-fills.

## Interface

- `NUM_OF_WORDS`, default 16: message length in 32-bit words; legal range 1..16.
- `clk`  in  1  sole clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  begin a fetch; sampled only in IDLE.
- `message_addr`  in  16  word address of message word 0.
- `mem_clk`  out  1  equals `clk`.
- `mem_we`  out  1  constant 0 (read-only client).
- `mem_addr`  out  16  registered read address.
- `mem_read_data`  in  32  memory read data; one-cycle registered latency.
- `block_data`  out  32 x 16  assembled block; word k in `block_data[k]`.
- `block_valid`  out  1  block complete and stable.
- `block_ready`  in  1  consumer accepts block.
- `busy`  out  1  high in FETCH, DRAIN and HOLD.
- `done`  out  1  one-cycle pulse after the block is accepted.

## Operation

- States: IDLE, FETCH, DRAIN, HOLD.
- IDLE → FETCH when `start`=1 at an edge:
  - latch `message_addr` as base;
  - clear fetch counter k to 0;
  - zero all 16 `block_data` words;
  - drive `mem_addr` = base.
- FETCH:
  - each cycle presents `mem_addr` = base + k (mod 2^16), then k increments;
  - the word returned for address base+j is written to `block_data[j]` at the edge one cycle after that address was presented;
  - after base+NUM_OF_WORDS-1 has been presented, go to DRAIN.
- DRAIN: capture the final word; go to HOLD.
- HOLD:
  - `block_valid`=1; `block_data` frozen;
  - when `block_ready`=1 at an edge, go to IDLE and pulse `done`.
- `block_data[j]` for j ≥ NUM_OF_WORDS stays 0.
- `start` is ignored outside IDLE. `block_ready` is ignored outside HOLD.
- `mem_addr` holds its last value outside FETCH.
- Address arithmetic is 16-bit unsigned and wraps: base 0xFFFF fetches 0xFFFF, 0x0000, 0x0001, ...
- Reset at any time, including mid-fetch or in HOLD:
  - immediately forces IDLE;
  - `mem_addr`=0, `mem_we`=0, all `block_data`=0, `block_valid`=0, `busy`=0, `done`=0;
  - any partial block is discarded.

## Timing

- Edge E0 samples `start`=1. Address base+k is on `mem_addr` during the cycle following edge E0+k, for k = 0..NUM_OF_WORDS-1.
- Word k is captured at edge E0+k+2.
- `block_valid` rises after edge E0+NUM_OF_WORDS+1, i.e. NUM_OF_WORDS+1 cycles after the start edge. For NUM_OF_WORDS=16 this is 17 cycles.
- `busy` rises after E0 and falls after the accepting edge.
- `block_ready` may already be high when `block_valid` first rises. The handshake then completes at the first HOLD edge, so HOLD lasts exactly one cycle.
- `done` is high exactly one cycle, following the accepting edge. The block is in IDLE during that cycle, so a `start` sampled then is accepted back-to-back.
- `block_data` stays stable from the `block_valid` rise until the next `start` is accepted.

## Test plan

- Reset then idle: all outputs 0; `mem_we` remains 0 throughout every test.
- NUM_OF_WORDS=16, base 0x0000, memory[j]=0xA5A50000+j, `block_ready` held high:
  - `mem_addr` steps 0x0000..0x000F;
  - `block_valid` rises 17 cycles after start and lasts 1 cycle, then `done` pulses;
  - `block_data[j]` = 0xA5A50000+j.
- NUM_OF_WORDS=5, base 0x0100:
  - `block_data[0..4]` = mem[0x100..0x104], `block_data[5..15]`=0;
  - `block_valid` at cycle 6;
  - `block_ready` withheld 10 cycles: `block_valid` and data stay stable and `done` stays low until acceptance.
- NUM_OF_WORDS=4, base 0xFFFE: addresses presented 0xFFFE, 0xFFFF, 0x0000, 0x0001; data lands in words 0..3.
- Reset asserted mid-FETCH, after 3 words:
  - outputs clear immediately and `block_valid` never asserts;
  - a new start with base 0x0200 then yields a clean block with no stale words.
- Back-to-back runs:
  - `start` asserted during the `done` cycle is accepted;
  - `start` pulses during FETCH and HOLD are ignored (no address restart, no second block).

Source files
------------

// File: rtl/sha256_block_loader_if.sv
// Handshake and memory-bus bundle between the SHA-256 block loader and its
// environment (word memory on one side, hash core on the other).
interface sha256_block_loader_if;
  logic               start;
  logic [15:0]        message_addr;
  logic               mem_clk;
  logic               mem_we;
  logic [15:0]        mem_addr;
  logic [31:0]        mem_read_data;
  logic [15:0][31:0]  block_data;
  logic               block_valid;
  logic               block_ready;
  logic               busy;
  logic               done;

  // Loader side
  modport master (
    input  start, message_addr, mem_read_data, block_ready,
    output mem_clk, mem_we, mem_addr, block_data, block_valid, busy, done
  );

  // Environment side (memory, core, controller)
  modport slave (
    output start, message_addr, mem_read_data, block_ready,
    input  mem_clk, mem_we, mem_addr, block_data, block_valid, busy, done
  );
endinterface

// File: rtl/sha256_block_loader.sv
// SHA-256 block loader: fetches NUM_OF_WORDS consecutive words from a
// word-addressed memory with one-cycle read latency, assembles a zero-filled
// 16-word block and offers it on a valid/ready handshake.
module sha256_block_loader #(
  parameter int NUM_OF_WORDS = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  sha256_block_loader_if.master  bus
);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, HOLD} state_t;

  localparam logic [3:0] LAST = 4'(NUM_OF_WORDS - 1);

  state_t             state_q, state_d;
  logic [15:0]        addr_q, addr_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [15:0][31:0]  block_q, block_d;
  logic               done_q, done_d;

  // Next-state and datapath update. cnt_q is the index of the address on
  // mem_addr; read data for that index arrives one cycle later, so FETCH
  // stores word cnt_q-1 and DRAIN stores the last word.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    block_d = block_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = FETCH;
          addr_d  = bus.message_addr;
          cnt_d   = '0;
          block_d = '0;
        end
      end
      FETCH: begin
        if (cnt_q != 4'd0) begin
          block_d[cnt_q - 4'd1] = bus.mem_read_data;
        end
        if (cnt_q == LAST) begin
          state_d = DRAIN;
        end else begin
          addr_d = addr_q + 16'd1;
          cnt_d  = cnt_q + 4'd1;
        end
      end
      DRAIN: begin
        block_d[LAST] = bus.mem_read_data;
        state_d       = HOLD;
      end
      HOLD: begin
        if (bus.block_ready) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register with asynchronous clear of every output-visible register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
      block_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      block_q <= block_d;
      done_q  <= done_d;
    end
  end

  assign bus.mem_clk     = clk;
  assign bus.mem_we      = 1'b0;
  assign bus.mem_addr    = addr_q;
  assign bus.block_data  = block_q;
  assign bus.block_valid = (state_q == HOLD);
  assign bus.busy        = (state_q != IDLE);
  assign bus.done        = done_q;

endmodule

// File: tb/tb_sha256_block_loader.sv
// Bench for sha256_block_loader: three instances (16, 5 and 4 words) run in
// lockstep on shared stimulus and are checked against a timing/data model.
module tb_sha256_block_loader;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] base;
  logic        ready;

  logic [31:0] mem [65536];

  logic [15:0]       addr_w  [3];
  logic              valid_w [3];
  logic              busy_w  [3];
  logic              done_w  [3];
  logic              we_w    [3];
  logic              mclk_w  [3];
  logic [15:0][31:0] data_w  [3];

  int unsigned n_chk;
  int unsigned n_pass;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    sha256_block_loader_if bus ();

    sha256_block_loader #(
      .NUM_OF_WORDS((g == 0) ? 16 : ((g == 1) ? 5 : 4))
    ) dut (
      .clk   (clk),
      .reset (rst),
      .bus   (bus)
    );

    assign bus.start        = start;
    assign bus.message_addr = base;
    assign bus.block_ready  = ready;

    // Memory with one-cycle registered read latency
    always @(posedge clk) bus.mem_read_data <= mem[bus.mem_addr];

    assign addr_w[g]  = bus.mem_addr;
    assign valid_w[g] = bus.block_valid;
    assign busy_w[g]  = bus.busy;
    assign done_w[g]  = bus.done;
    assign we_w[g]    = bus.mem_we;
    assign mclk_w[g]  = bus.mem_clk;
    assign data_w[g]  = bus.block_data;
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  function automatic int unsigned nw(input int unsigned g);
    case (g)
      0:       return 16;
      1:       return 5;
      default: return 4;
    endcase
  endfunction

  // Every output of every instance must be in its reset value.
  task automatic check_cleared(input string tag);
    for (int unsigned g = 0; g < 3; g++) begin
      chk($sformatf("%s_addr%0d", tag, g),  32'(addr_w[g]),  32'h0);
      chk($sformatf("%s_valid%0d", tag, g), 32'(valid_w[g]), 32'h0);
      chk($sformatf("%s_busy%0d", tag, g),  32'(busy_w[g]),  32'h0);
      chk($sformatf("%s_done%0d", tag, g),  32'(done_w[g]),  32'h0);
      chk($sformatf("%s_we%0d", tag, g),    32'(we_w[g]),    32'h0);
      for (int unsigned j = 0; j < 16; j++)
        chk($sformatf("%s_data%0d_%0d", tag, g, j), data_w[g][j], 32'h0);
    end
  endtask

  // One block transfer. Entered and left on a negedge. Cycle c is the cycle
  // after start edge E0+c. r is the first cycle in which ready is high.
  task automatic run(input logic [15:0] b, input int unsigned r, input bit spur);
    int unsigned a [3];
    int unsigned amax;
    int unsigned amin;
    int unsigned n;
    logic [31:0] exp_w [3][16];
    logic [15:0] ea;

    amax = 0;
    amin = 100000;
    for (int unsigned g = 0; g < 3; g++) begin
      n    = nw(g);
      a[g] = (r > n + 1) ? r : n + 1;
      if (a[g] > amax) amax = a[g];
      if (a[g] < amin) amin = a[g];
      for (int unsigned j = 0; j < 16; j++)
        exp_w[g][j] = (j < n) ? mem[16'(32'(b) + j)] : 32'h0;
    end

    start = 1'b1;
    base  = b;
    ready = (r == 0);
    @(posedge clk);
    for (int unsigned c = 0; c <= amax + 1; c++) begin
      @(negedge clk);
      for (int unsigned g = 0; g < 3; g++) begin
        n  = nw(g);
        ea = 16'(32'(b) + ((c < n) ? c : n - 1));
        chk($sformatf("addr%0d_c%0d", g, c),  32'(addr_w[g]), 32'(ea));
        chk($sformatf("valid%0d_c%0d", g, c), 32'(valid_w[g]), 32'(c >= n + 1 && c <= a[g]));
        chk($sformatf("busy%0d_c%0d", g, c),  32'(busy_w[g]),  32'(c <= a[g]));
        chk($sformatf("done%0d_c%0d", g, c),  32'(done_w[g]),  32'(c == a[g] + 1));
        chk($sformatf("we%0d_c%0d", g, c),    32'(we_w[g]),    32'h0);
        chk($sformatf("mclk%0d_c%0d", g, c),  32'(mclk_w[g]),  32'(clk));
        if (c == 1) begin
          for (int unsigned j = 0; j < 16; j++)
            chk($sformatf("zero%0d_%0d", g, j), data_w[g][j], 32'h0);
        end
        if (c >= n + 1) begin
          for (int unsigned j = 0; j < 16; j++)
            chk($sformatf("data%0d_%0d_c%0d", g, j, c), data_w[g][j], exp_w[g][j]);
        end
      end
      start = spur && (c >= 1) && (c <= amin) && ($urandom_range(0, 2) == 0);
      base  = 16'($urandom);
      ready = (c >= r);
    end
    start = 1'b0;
  endtask

  // Reset mid-fetch after three words are captured, then a clean block.
  task automatic reset_mid();
    start = 1'b1;
    base  = 16'h0300;
    ready = 1'b0;
    @(posedge clk);
    for (int unsigned c = 0; c < 4; c++) begin
      @(negedge clk);
      start = 1'b0;
      for (int unsigned g = 0; g < 3; g++)
        chk($sformatf("rm_addr%0d_c%0d", g, c), 32'(addr_w[g]),
            32'(16'(32'h0300 + ((c < nw(g)) ? c : nw(g) - 1))));
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_cleared("rst_mid");
    @(negedge clk);
    rst   = 1'b0;
    ready = 1'b1;
    for (int unsigned c = 0; c < 6; c++) begin
      @(negedge clk);
      for (int unsigned g = 0; g < 3; g++) begin
        chk($sformatf("post_rst_valid%0d", g), 32'(valid_w[g]), 32'h0);
        chk($sformatf("post_rst_busy%0d", g),  32'(busy_w[g]),  32'h0);
      end
    end
    ready = 1'b0;
    run(16'h0200, 2, 1'b0);
  endtask

  initial begin
    n_chk  = 0;
    n_pass = 0;
    rst    = 1'b1;
    start  = 1'b0;
    base   = '0;
    ready  = 1'b0;
    for (int unsigned i = 0; i < 65536; i++) mem[i] = $urandom;
    for (int unsigned j = 0; j < 16; j++) mem[j] = 32'hA5A5_0000 + j;

    repeat (3) @(negedge clk);
    check_cleared("reset");
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check_cleared("idle");

    run(16'h0000, 0, 1'b0);
    repeat (2) @(negedge clk);
    run(16'h0100, 16, 1'b0);
    run(16'hFFFE, 3, 1'b1);
    repeat (1) @(negedge clk);
    reset_mid();

    for (int unsigned i = 0; i < 8; i++) begin
      if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) @(negedge clk);
      run(16'($urandom), $urandom_range(0, 24), 1'b1);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
